// File: rtl/si_header_detacher.sv
// -----------------------------------------------------------------------------
// si_header_detacher
//
// Strips the two SI header words from every packet on a 128-bit AXI-Stream
// and forwards only the payload words through one registered output stage.
// The sequence number carried in the second header word is captured and
// reported with a one-cycle pulse. Malformed packets are discarded whole.
//
// Parameters
//   DATA_WIDTH  stream word width (only 128 is supported)
//   KEEP_WIDTH  tkeep width, (DATA_WIDTH+7)/8
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   s_axis_*                      input stream from the header parser
//   m_axis_*                      payload-only output stream
//   sequence_o                    sequence number of the current packet
//                                 ('sequence' is a reserved word in SV)
//   sequence_valid                one-cycle pulse when sequence_o updates
//   resync                        one-cycle pulse when a truncated header
//                                 is abandoned for a new word 0
//   dropped_packet                one-cycle pulse when a packet is discarded
//                                 without any payload forwarded
//   stat_packets/resyncs/dropped  32-bit wrapping counters, present only when
//                                 SI_HEADER_DETACHER_STATS_EN is defined
// -----------------------------------------------------------------------------
module si_header_detacher #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,

  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,

  output logic [31:0]           sequence_o,
  output logic                  sequence_valid,
  output logic                  resync,
`ifdef SI_HEADER_DETACHER_STATS_EN
  output logic [31:0]           stat_packets,
  output logic [31:0]           stat_resyncs,
  output logic [31:0]           stat_dropped,
`endif
  output logic                  dropped_packet
);

  generate
    if (DATA_WIDTH != 128 || KEEP_WIDTH != 16) begin : g_bad_width
      $error("si_header_detacher supports only DATA_WIDTH=128 / KEEP_WIDTH=16");
    end
  endgenerate

  localparam logic [31:0]           SI_MAGIC  = 32'h4953_9B80;
  localparam logic [31:0]           TT_MAGIC  = 32'h0000_5454;
  localparam logic [KEEP_WIDTH-1:0] KEEP_FULL = '1;

  typedef enum logic [1:0] {
    ST_HDR0    = 2'd0,
    ST_HDR1    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } state_e;

  state_e                  state_q, state_d;

  logic                    m_valid_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic [KEEP_WIDTH-1:0]   m_keep_q;
  logic                    m_last_q;
  logic [31:0]             seq_q;
  logic                    seq_valid_q;
  logic                    resync_q;
  logic                    dropped_q;

  logic                    s_hs;
  logic                    si_check;
  logic                    tt_check;
  logic                    ev_seq;
  logic                    ev_resync;
  logic                    ev_drop;
  logic                    ev_enter_payload;
  logic                    fwd;

  // Only PAYLOAD can be back-pressured; header and drop words are always
  // consumed so the parser is never stalled by a packet that yields no output.
  assign s_axis_tready = (state_q != ST_PAYLOAD) || !m_valid_q || m_axis_tready;
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  assign si_check = (s_axis_tkeep == KEEP_FULL) && (s_axis_tdata[127:96] == SI_MAGIC);
  assign tt_check = (s_axis_tkeep == KEEP_FULL) && (s_axis_tdata[31:0]   == TT_MAGIC);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d          = state_q;
    ev_seq           = 1'b0;
    ev_resync        = 1'b0;
    ev_drop          = 1'b0;
    ev_enter_payload = 1'b0;
    fwd              = 1'b0;

    if (s_hs) begin
      unique case (state_q)
        ST_HDR0: begin
          if (s_axis_tlast) begin
            ev_drop = 1'b1;                 // single-word packet: nothing to strip
          end else if (si_check) begin
            state_d = ST_HDR1;
          end else begin
            state_d = ST_DROP;
            ev_drop = 1'b1;
          end
        end

        ST_HDR1: begin
          if (tt_check) begin
            ev_seq = 1'b1;
            if (s_axis_tlast) begin
              state_d = ST_HDR0;            // valid header but empty payload
              ev_drop = 1'b1;
            end else begin
              state_d          = ST_PAYLOAD;
              ev_enter_payload = 1'b1;
            end
          end else if (si_check && !s_axis_tlast) begin
            // Previous header was truncated; this word restarts as word 0.
            ev_resync = 1'b1;
          end else begin
            state_d = s_axis_tlast ? ST_HDR0 : ST_DROP;
            ev_drop = 1'b1;
          end
        end

        ST_PAYLOAD: begin
          fwd = 1'b1;
          if (s_axis_tlast) state_d = ST_HDR0;
        end

        ST_DROP: begin
          if (s_axis_tlast) state_d = ST_HDR0;
        end

        default: state_d = ST_HDR0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the output data registers are reset as well, not just the valid
      // flag, because the reset values of tdata/tkeep are externally visible.
      state_q     <= ST_HDR0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      seq_q       <= '0;
      seq_valid_q <= 1'b0;
      resync_q    <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_valid_q <= ev_seq;
      resync_q    <= ev_resync;
      dropped_q   <= ev_drop;
      if (ev_seq) seq_q <= s_axis_tdata[95:64];

      // fwd implies the stage is empty or draining this cycle, so the held
      // word is never overwritten while stalled.
      if (fwd) begin
        m_valid_q <= 1'b1;
        m_data_q  <= s_axis_tdata;
        m_keep_q  <= s_axis_tkeep;
        m_last_q  <= s_axis_tlast;
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid  = m_valid_q;
  assign m_axis_tdata   = m_data_q;
  assign m_axis_tkeep   = m_keep_q;
  assign m_axis_tlast   = m_last_q;
  assign sequence_o     = seq_q;
  assign sequence_valid = seq_valid_q;
  assign resync         = resync_q;
  assign dropped_packet = dropped_q;

`ifdef SI_HEADER_DETACHER_STATS_EN
  logic [31:0] stat_packets_q, stat_resyncs_q, stat_dropped_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_packets_q <= '0;
      stat_resyncs_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      if (ev_enter_payload) stat_packets_q <= stat_packets_q + 32'd1;
      if (ev_resync)        stat_resyncs_q <= stat_resyncs_q + 32'd1;
      if (ev_drop)          stat_dropped_q <= stat_dropped_q + 32'd1;
    end
  end

  assign stat_packets = stat_packets_q;
  assign stat_resyncs = stat_resyncs_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_si_header_detacher.sv
// -----------------------------------------------------------------------------
// Testbench for si_header_detacher. Expected payload beats are pushed to a
// queue as stimulus is driven; a negedge monitor pops and compares them on
// every output handshake and checks stability during back-pressure.
// -----------------------------------------------------------------------------
module tb_si_header_detacher;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata = '0;
  logic         s_axis_tlast = 1'b0;
  logic [15:0]  s_axis_tkeep = '0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic [15:0]  m_axis_tkeep;
  logic [31:0]  sequence_o;
  logic         sequence_valid;
  logic         resync;
  logic         dropped_packet;
`ifdef SI_HEADER_DETACHER_STATS_EN
  logic [31:0]  stat_packets, stat_resyncs, stat_dropped;
`endif

  si_header_detacher dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tkeep   (s_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tkeep   (m_axis_tkeep),
    .sequence_o     (sequence_o),
    .sequence_valid (sequence_valid),
    .resync         (resync),
`ifdef SI_HEADER_DETACHER_STATS_EN
    .stat_packets   (stat_packets),
    .stat_resyncs   (stat_resyncs),
    .stat_dropped   (stat_dropped),
`endif
    .dropped_packet (dropped_packet)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  beat_t exp_q[$];
  int    n_seq = 0, n_resync = 0, n_drop = 0;
  bit    toggle_en = 1'b0;

  // m_axis_tready toggler for the back-pressure scenario.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) m_axis_tready = ~m_axis_tready;
    end
  end

  // Output monitor: scoreboard pop, stall stability, pulse counting.
  bit    stall_prev = 1'b0;
  beat_t stall_beat;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== stall_beat.d ||
            m_axis_tkeep !== stall_beat.k || m_axis_tlast !== stall_beat.l) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b, required v=1 d=%h k=%h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                   stall_beat.d, stall_beat.k, stall_beat.l);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got d=%h k=%h l=%b, required no output",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k || m_axis_tlast !== e.l) begin
            miscompares++;
            $display("FAIL output_beat: got d=%h k=%h l=%b, required d=%h k=%h l=%b",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast, e.d, e.k, e.l);
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_beat = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
      if (sequence_valid) n_seq++;
      if (resync)         n_resync++;
      if (dropped_packet) n_drop++;
    end
  end

  function automatic logic [127:0] si_word(input logic [31:0] tag);
    return {32'h4953_9B80, 32'h0, 32'h0, tag};
  endfunction

  function automatic logic [127:0] tt_word(input logic [31:0] seq);
    return {32'h0102_0304, seq, 32'h0, 32'h0000_5454};
  endfunction

  function automatic logic [127:0] pay_word(input int n);
    return {4{32'hA5A0_0000 + 32'(n)}};
  endfunction

  // Drive one input word and return after its handshake edge (+1).
  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l,
                      output int waits);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      waits++;
      if (waits > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: got tready=0 for %0d cycles, required handshake", waits);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_payload(input int n, input logic [15:0] k, input logic l);
    int w;
    exp_q.push_back('{d: pay_word(n), k: k, l: l});
    send(pay_word(n), k, l, w);
  endtask

  task automatic send_packet(input logic [31:0] seq, input int n_pay, input int base);
    int w;
    send(si_word(32'h1), 16'hFFFF, 1'b0, w);
    send(tt_word(seq), 16'hFFFF, 1'b0, w);
    for (int i = 0; i < n_pay; i++)
      send_payload(base + i, (i == n_pay - 1) ? 16'h00FF : 16'hFFFF, i == n_pay - 1);
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic clear_counts();
    n_seq = 0; n_resync = 0; n_drop = 0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 ||
        m_axis_tlast !== 1'b0 || sequence_o !== '0 || sequence_valid !== 1'b0 ||
        resync !== 1'b0 || dropped_packet !== 1'b0 || s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b d=%h k=%h l=%b seq=%h pulses=%b%b%b rdy=%b, required all 0, rdy=1",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, sequence_o,
               sequence_valid, resync, dropped_packet, s_axis_tready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_packet();
    int w;
    clear_counts();
    send(si_word(32'h1), 16'hFFFF, 1'b0, w);
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL hdr0_not_forwarded: got tvalid=%b, required 0", m_axis_tvalid);
    end
    send(tt_word(32'h0000_0005), 16'hFFFF, 1'b0, w);
    vectors++;
    if (sequence_valid !== 1'b1 || sequence_o !== 32'h5 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_pulse_timing: got pulse=%b seq=%h tvalid=%b, required 1 00000005 0",
               sequence_valid, sequence_o, m_axis_tvalid);
    end
    for (int i = 0; i < 3; i++) begin
      send_payload(10 + i, (i == 2) ? 16'h00FF : 16'hFFFF, i == 2);
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pay_word(10 + i)) begin
        miscompares++;
        $display("FAIL latency_1: got tvalid=%b d=%h, required 1 %h",
                 m_axis_tvalid, m_axis_tdata, pay_word(10 + i));
      end
    end
    wait_drain();
    vectors++;
    if (n_seq != 1 || sequence_o !== 32'h5 || n_drop != 0) begin
      miscompares++;
      $display("FAIL basic_pulses: got seq_pulses=%0d seq=%h drops=%0d, required 1 00000005 0",
               n_seq, sequence_o, n_drop);
    end
  endtask

  task automatic test_backpressure();
    clear_counts();
    toggle_en = 1'b1;
    send_packet(32'h0000_0005, 3, 10);
    wait_drain();
    toggle_en = 1'b0;
    m_axis_tready = 1'b1;
    vectors++;
    if (n_seq != 1 || sequence_o !== 32'h5) begin
      miscompares++;
      $display("FAIL backpressure_seq: got pulses=%0d seq=%h, required 1 00000005", n_seq, sequence_o);
    end
  endtask

  task automatic test_resync();
    int w;
    clear_counts();
    send(si_word(32'h1), 16'hFFFF, 1'b0, w);
    send(si_word(32'h2), 16'hFFFF, 1'b0, w);
    vectors++;
    if (resync !== 1'b1) begin
      miscompares++;
      $display("FAIL resync_pulse_timing: got %b, required 1", resync);
    end
    send(tt_word(32'h0000_0007), 16'hFFFF, 1'b0, w);
    send_payload(20, 16'hFFFF, 1'b1);
    wait_drain();
    vectors++;
    if (n_resync != 1 || n_seq != 1 || sequence_o !== 32'h7 || n_drop != 0) begin
      miscompares++;
      $display("FAIL resync_counts: got resync=%0d seq_pulses=%0d seq=%h drops=%0d, required 1 1 00000007 0",
               n_resync, n_seq, sequence_o, n_drop);
    end
  endtask

  task automatic test_drop_arp();
    int w;
    logic [127:0] arp;
    clear_counts();
    arp = {32'h0806_0001, 96'h0};
    for (int i = 0; i < 4; i++) begin
      send(arp + 128'(i), 16'hFFFF, i == 3, w);
      vectors++;
      if (w != 0 || s_axis_tready !== 1'b1) begin
        miscompares++;
        $display("FAIL drop_tready: got waits=%0d tready=%b, required 0 1", w, s_axis_tready);
      end
    end
    // Single-word packet in HDR0 is also dropped.
    send(si_word(32'h3), 16'hFFFF, 1'b1, w);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (n_drop != 2 || n_seq != 0 || sequence_o !== 32'h7 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_counts: got drops=%0d seq_pulses=%0d seq=%h tvalid=%b, required 2 0 00000007 0",
               n_drop, n_seq, sequence_o, m_axis_tvalid);
    end
  endtask

  task automatic test_tt_last();
    int w;
    clear_counts();
    send(si_word(32'h1), 16'hFFFF, 1'b0, w);
    send(tt_word(32'h1234_5678), 16'hFFFF, 1'b1, w);
    vectors++;
    if (dropped_packet !== 1'b1 || sequence_valid !== 1'b1 || sequence_o !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL tt_last_pulses: got drop=%b seqv=%b seq=%h, required 1 1 12345678",
               dropped_packet, sequence_valid, sequence_o);
    end
    send_packet(32'h0000_0009, 2, 30);
    wait_drain();
    vectors++;
    if (n_drop != 1 || n_seq != 2 || sequence_o !== 32'h9) begin
      miscompares++;
      $display("FAIL tt_last_counts: got drops=%0d seq_pulses=%0d seq=%h, required 1 2 00000009",
               n_drop, n_seq, sequence_o);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    send_packet(32'h0000_000A, 2, 40);
    send(si_word(32'h1), 16'hFFFF, 1'b0, w);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL b2b_word0_accept: got %0d wait cycles, required 0", w);
    end
    send(tt_word(32'h0000_000B), 16'hFFFF, 1'b0, w);
    send_payload(50, 16'h0003, 1'b1);
    wait_drain();
    vectors++;
    if (sequence_o !== 32'hB) begin
      miscompares++;
      $display("FAIL b2b_seq: got %h, required 0000000b", sequence_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    int w;
    m_axis_tready = 1'b0;
    send(si_word(32'h1), 16'hFFFF, 1'b0, w);
    send(tt_word(32'h0000_0011), 16'hFFFF, 1'b0, w);
    send_payload(60, 16'hFFFF, 1'b0);
    s_axis_tdata  = pay_word(61);
    s_axis_tkeep  = 16'hFFFF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || sequence_o !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got tvalid=%b d=%h seq=%h, required 0 0 0",
               m_axis_tvalid, m_axis_tdata, sequence_o);
    end
    exp_q.delete();
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;
    clear_counts();
    send_packet(32'h0000_0012, 4, 70);
    wait_drain();
    vectors++;
    if (n_seq != 1 || sequence_o !== 32'h12 || n_drop != 0) begin
      miscompares++;
      $display("FAIL post_reset_packet: got seq_pulses=%0d seq=%h drops=%0d, required 1 00000012 0",
               n_seq, sequence_o, n_drop);
    end
  endtask

`ifdef SI_HEADER_DETACHER_STATS_EN
  task automatic test_stats();
    vectors++;
    if (stat_packets !== 32'd1 || stat_resyncs !== 32'd0 || stat_dropped !== 32'd0) begin
      miscompares++;
      $display("FAIL stats: got %0d %0d %0d, required 1 0 0", stat_packets, stat_resyncs, stat_dropped);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_packet();
    test_backpressure();
    test_resync();
    test_drop_arp();
    test_tt_last();
    test_back_to_back();
    test_reset_mid_packet();
`ifdef SI_HEADER_DETACHER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
